// File: rtl/mc_pkg.sv
// Shared definitions for the MC port responder: size codes, byte-lane enables,
// and the flush state machine encoding.
package mc_pkg;

  localparam logic [1:0] MC_SZ_1B = 2'd0;
  localparam logic [1:0] MC_SZ_2B = 2'd1;
  localparam logic [1:0] MC_SZ_4B = 2'd2;
  localparam logic [1:0] MC_SZ_8B = 2'd3;

  typedef enum logic [1:0] {FL_IDLE, FL_DRAIN, FL_DONE} mc_flush_e;

  // Lane mask for a naturally aligned access of the given size at byte offset.
  function automatic logic [7:0] mc_byte_en(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] lanes;
    case (size)
      MC_SZ_1B: lanes = 8'h01;
      MC_SZ_2B: lanes = 8'h03;
      MC_SZ_4B: lanes = 8'h0f;
      default:  lanes = 8'hff;
    endcase
    return lanes << offset;
  endfunction

endpackage

// File: rtl/mc_rsp_fifo.sv
// Show-ahead synchronous FIFO holding load responses (data + rdctl) with an
// occupancy count. The writer guarantees it is never written while full.
module mc_rsp_fifo #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mc_port_responder.sv
// Memory-controller end of one MC port: services ld/st/flush from a local
// 64-bit-word RAM and returns load data in request order with its rdctl tag.
module mc_port_responder
  import mc_pkg::*;
#(
  parameter int unsigned AW   = 10,
  parameter int unsigned LAT  = 4,
  parameter int unsigned QD   = 16,
  parameter int unsigned SKID = 4
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        req_ld,
  input  logic        req_st,
  input  logic [1:0]  req_size,
  input  logic [47:0] req_vadr,
  input  logic [63:0] req_wrd_rdctl,
  input  logic        req_flush,
  input  logic        rsp_stall,
  output logic        rd_rq_stall,
  output logic        wr_rq_stall,
  output logic [63:0] rsp_data,
  output logic        rsp_push,
  output logic [31:0] rsp_rdctl,
  output logic        rsp_flush_cmplt,
  output logic        err_overflow,
  output logic        err_proto
);

  localparam int unsigned CW = $clog2(QD + 1);
  localparam logic [CW-1:0] QD_MAX = CW'(QD);
  localparam logic [CW-1:0] RD_TH  = CW'(QD - SKID);

  logic [63:0]   ram [2**AW];
  logic [AW-1:0] widx;
  logic [2:0]    boff;
  logic [7:0]    wr_be;
  logic [63:0]   wr_data;
  logic          both_req, ld_req, st_acc, ld_acc, ld_ovf, pop;
  logic [CW-1:0] out_q, out_d, snap_q, fifo_cnt;
  logic [95:0]   ld_word, fifo_wdata, fifo_rdata;
  logic          fifo_wr;
  mc_flush_e     fl_q;
  logic          unused_vadr;

  assign widx        = req_vadr[AW+2:3];
  assign boff        = req_vadr[2:0];
  assign unused_vadr = ^req_vadr[47:AW+3];
  assign wr_be       = mc_byte_en(req_size, boff);
  assign wr_data     = req_wrd_rdctl << {boff, 3'b000};

  assign both_req = req_ld & req_st;
  assign ld_req   = req_ld & ~req_st;
  assign st_acc   = req_st & ~req_ld;
  assign ld_acc   = ld_req & (out_q != QD_MAX);
  assign ld_ovf   = ld_req & (out_q == QD_MAX);
  assign pop      = (fifo_cnt != '0) & ~rsp_stall;
  assign out_d    = out_q + CW'(ld_acc) - CW'(pop);
  assign ld_word  = {ram[widx], req_wrd_rdctl[31:0]};

  always_ff @(posedge clk) begin
    if (st_acc) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be[b]) ram[widx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // The FIFO write is the LAT-th stage, so only LAT-1 register stages precede it.
  if (LAT == 1) begin : g_nopipe
    assign fifo_wr    = ld_acc;
    assign fifo_wdata = ld_word;
  end else begin : g_pipe
    logic [LAT-2:0] pv_q;
    logic [95:0]    pd_q [LAT-1];

    always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
        pv_q <= '0;
      end else begin
        pv_q[0] <= ld_acc;
        for (int i = 1; i < LAT - 1; i++) pv_q[i] <= pv_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pd_q[0] <= ld_word;
      for (int i = 1; i < LAT - 1; i++) pd_q[i] <= pd_q[i-1];
    end

    assign fifo_wr    = pv_q[LAT-2];
    assign fifo_wdata = pd_q[LAT-2];
  end

  mc_rsp_fifo #(
    .W    (96),
    .DEPTH(QD)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst    (i_reset),
    .wr_en  (fifo_wr),
    .wr_data(fifo_wdata),
    .rd_en  (pop),
    .rd_data(fifo_rdata),
    .count  (fifo_cnt)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      out_q           <= '0;
      snap_q          <= '0;
      fl_q            <= FL_IDLE;
      rd_rq_stall     <= 1'b0;
      wr_rq_stall     <= 1'b0;
      rsp_data        <= '0;
      rsp_push        <= 1'b0;
      rsp_rdctl       <= '0;
      rsp_flush_cmplt <= 1'b0;
      err_overflow    <= 1'b0;
      err_proto       <= 1'b0;
    end else begin
      out_q       <= out_d;
      rd_rq_stall <= (out_d >= RD_TH);
      rsp_push    <= pop;
      if (pop) begin
        rsp_data  <= fifo_rdata[95:32];
        rsp_rdctl <= fifo_rdata[31:0];
      end
      if (ld_ovf) err_overflow <= 1'b1;
      if (both_req || (req_flush && fl_q != FL_IDLE)) err_proto <= 1'b1;

      // Snapshot counts loads still owed a push, including one accepted this cycle.
      case (fl_q)
        FL_IDLE: begin
          if (req_flush) begin
            fl_q        <= FL_DRAIN;
            snap_q      <= out_d;
            wr_rq_stall <= 1'b1;
          end
        end
        FL_DRAIN: begin
          if (snap_q == '0) begin
            fl_q            <= FL_DONE;
            rsp_flush_cmplt <= 1'b1;
          end else if (pop) begin
            snap_q <= snap_q - 1'b1;
          end
        end
        FL_DONE: begin
          fl_q            <= FL_IDLE;
          rsp_flush_cmplt <= 1'b0;
          wr_rq_stall     <= 1'b0;
        end
        default: fl_q <= FL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_port_responder.sv
// Randomised scoreboard bench for mc_port_responder with directed boundary cases.
module tb_mc_port_responder;

  localparam int AW = 10, LAT = 4, QD = 16, SKID = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        req_ld, req_st, req_flush, rsp_stall;
  logic [1:0]  req_size;
  logic [47:0] req_vadr;
  logic [63:0] req_wrd_rdctl;
  logic        rd_rq_stall, wr_rq_stall, rsp_push, rsp_flush_cmplt, err_overflow, err_proto;
  logic [63:0] rsp_data;
  logic [31:0] rsp_rdctl;

  mc_port_responder #(.AW(AW), .LAT(LAT), .QD(QD), .SKID(SKID)) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .req_ld         (req_ld),
    .req_st         (req_st),
    .req_size       (req_size),
    .req_vadr       (req_vadr),
    .req_wrd_rdctl  (req_wrd_rdctl),
    .req_flush      (req_flush),
    .rsp_stall      (rsp_stall),
    .rd_rq_stall    (rd_rq_stall),
    .wr_rq_stall    (wr_rq_stall),
    .rsp_data       (rsp_data),
    .rsp_push       (rsp_push),
    .rsp_rdctl      (rsp_rdctl),
    .rsp_flush_cmplt(rsp_flush_cmplt),
    .err_overflow   (err_overflow),
    .err_proto      (err_proto)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [31:0] tag;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem_m [1024];
  int          chk = 0;
  int          err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!i_reset && rsp_push) begin
      if (sb.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_push actual rdctl=0x%0h required no response", rsp_rdctl);
      end else begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_rdctl", {32'h0, rsp_rdctl}, {32'h0, e.tag});
      end
    end
  end

  task automatic store(input logic [1:0] sz, input logic [47:0] a, input logic [63:0] d);
    int idx = int'(a[12:3]);
    int off = int'(a[2:0]);
    req_st = 1'b1; req_size = sz; req_vadr = a; req_wrd_rdctl = d;
    for (int b = 0; b < (1 << sz); b++) mem_m[idx][8*(off+b) +: 8] = d[8*b +: 8];
    @(posedge clk); #1;
    req_st = 1'b0;
  endtask

  task automatic load_exp(input logic [47:0] a, input logic [31:0] tag, input logic [63:0] exp,
                          input logic acc);
    exp_t e;
    req_ld = 1'b1; req_size = 2'd3; req_vadr = a; req_wrd_rdctl = {32'h0, tag};
    if (acc) begin
      e.data = exp;
      e.tag  = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_ld = 1'b0;
  endtask

  task automatic load(input logic [47:0] a, input logic [31:0] tag);
    load_exp(a, tag, mem_m[int'(a[12:3])], 1'b1);
  endtask

  task automatic flush_pulse();
    req_flush = 1'b1;
    @(posedge clk); #1;
    req_flush = 1'b0;
  endtask

  task automatic drain(input int budget);
    rsp_stall = 1'b0;
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int c, pushes;
    logic found;
    logic [47:0] a;
    logic [1:0]  sz;
    i_reset = 1'b1; req_ld = 0; req_st = 0; req_flush = 0; rsp_stall = 0;
    req_size = 0; req_vadr = 0; req_wrd_rdctl = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_push", rsp_push, 0);
    check("reset_rd_rq_stall", rd_rq_stall, 0);
    check("reset_wr_rq_stall", wr_rq_stall, 0);
    check("reset_err_overflow", err_overflow, 0);
    check("reset_err_proto", err_proto, 0);
    @(negedge clk) i_reset = 1'b0;
    @(posedge clk); #1;

    // Full-word store then load, with latency check.
    store(2'd3, 48'h40, 64'h1122334455667788);
    c = cyc;
    load_exp(48'h40, 32'hA5, 64'h1122334455667788, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_push) begin found = 1'b1; break; end
    end
    check("first_load_latency", found ? cyc : -1, c + LAT + 1);
    @(posedge clk); #1;

    // Byte store into the same word.
    store(2'd0, 48'h43, 64'hEE);
    load_exp(48'h40, 32'h1, 64'h11223344EE667788, 1'b1);
    drain(50);

    // Fill to QD with responses stalled, then overflow.
    rsp_stall = 1'b1;
    for (int i = 0; i < QD; i++) begin
      load(48'h40, i);
      check("rd_rq_stall_fill", rd_rq_stall, (i + 1 >= QD - SKID));
    end
    check("err_overflow_before", err_overflow, 0);
    load_exp(48'h40, 32'd16, 64'h0, 1'b0);
    check("err_overflow_after", err_overflow, 1);
    drain(100);

    // Flush with nothing outstanding.
    flush_pulse();
    check("flush0_wr_stall", wr_rq_stall, 1);
    check("flush0_cmplt_drain", rsp_flush_cmplt, 0);
    @(posedge clk); #1;
    check("flush0_cmplt_pulse", rsp_flush_cmplt, 1);
    @(posedge clk); #1;
    check("flush0_cmplt_end", rsp_flush_cmplt, 0);
    check("flush0_wr_stall_end", wr_rq_stall, 0);

    // Flush with three loads outstanding.
    rsp_stall = 1'b1;
    for (int i = 0; i < 3; i++) load(48'h40, 32'h30 + i);
    flush_pulse();
    check("flush3_wr_stall", wr_rq_stall, 1);
    repeat (10) begin
      @(posedge clk); #1;
      check("flush3_no_early_cmplt", rsp_flush_cmplt, 0);
    end
    rsp_stall = 1'b0;
    pushes = 0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_push) pushes++;
      if (rsp_flush_cmplt) begin found = 1'b1; break; end
    end
    check("flush3_cmplt_seen", found, 1);
    check("flush3_pushes_before_cmplt", pushes, 3);
    @(negedge clk);
    check("flush3_cmplt_single", rsp_flush_cmplt, 0);
    check("flush3_wr_stall_end", wr_rq_stall, 0);
    @(posedge clk); #1;

    // Simultaneous ld and st: neither executes.
    check("err_proto_before", err_proto, 0);
    req_ld = 1'b1; req_st = 1'b1; req_size = 2'd3; req_vadr = 48'h40; req_wrd_rdctl = '0;
    @(posedge clk); #1;
    req_ld = 1'b0; req_st = 1'b0;
    check("err_proto_after", err_proto, 1);
    load_exp(48'h40, 32'h55, 64'h11223344EE667788, 1'b1);
    drain(50);

    // Randomised traffic over a small initialised region.
    for (int w = 0; w < 16; w++) store(2'd3, 48'h100 + 8 * w, {$urandom, $urandom});
    for (int n = 0; n < 400; n++) begin
      rsp_stall = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 2))
        0: begin
          sz = 2'($urandom_range(0, 3));
          a  = 48'h100 + 48'(8 * $urandom_range(0, 15))
             + 48'((($urandom_range(0, 7) >> sz) << sz));
          store(sz, a, {$urandom, $urandom});
        end
        1: begin
          if (sb.size() < 10)
            load(48'h100 + 48'(8 * $urandom_range(0, 15)) + 48'($urandom_range(0, 7)), $urandom);
          else begin @(posedge clk); #1; end
        end
        default: begin @(posedge clk); #1; end
      endcase
    end
    drain(200);

    // Asynchronous reset with loads in flight.
    rsp_stall = 1'b1;
    for (int i = 0; i < 5; i++) load(48'h40, 32'h70 + i);
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_rsp_push", rsp_push, 0);
    check("async_rst_rsp_data", rsp_data, 0);
    check("async_rst_rsp_rdctl", rsp_rdctl, 0);
    check("async_rst_err_overflow", err_overflow, 0);
    check("async_rst_err_proto", err_proto, 0);
    check("async_rst_wr_rq_stall", wr_rq_stall, 0);
    check("async_rst_cmplt", rsp_flush_cmplt, 0);
    sb.delete();
    @(negedge clk) i_reset = 1'b0;
    rsp_stall = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rsp_stall = 1'b1;
    for (int i = 0; i < QD - SKID; i++) begin
      load(48'h40, 32'h90 + i);
      check("rd_rq_stall_after_rst", rd_rq_stall, (i + 1 >= QD - SKID));
    end
    drain(100);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
